// File: rtl/processor_core.sv
// Multicycle FETCH/EXEC/MEM core. Drives an external sync-read ROM and RAM and an
// external regfile with combinational reads; all decode is taken from q_imem.
module processor_core (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] address_imem,
    input  logic [31:0] q_imem,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [4:0]  ctrl_readRegA,
    output logic [4:0]  ctrl_readRegB,
    output logic [31:0] data_writeReg,
    input  logic [31:0] data_readRegA,
    input  logic [31:0] data_readRegB,
    output logic        wren,
    output logic [31:0] address_dmem,
    output logic [31:0] data,
    input  logic [31:0] q_dmem
);
    typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXEC = 2'd1, S_MEM = 2'd2} state_e;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_OR  = 5'b00011;
    localparam logic [4:0] ALU_SLL = 5'b00100;
    localparam logic [4:0] ALU_SRA = 5'b00101;

    localparam logic [4:0] REG_STATUS = 5'd30;
    localparam logic [4:0] REG_LINK   = 5'd31;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;

    logic [4:0]  opcode, rd, rs, rt, shamt, aluop;
    logic [31:0] imm_sext, target;
    logic        is_rtype, is_lw, is_sw, is_bex, reads_rd;

    assign opcode   = q_imem[31:27];
    assign rd       = q_imem[26:22];
    assign rs       = q_imem[21:17];
    assign rt       = q_imem[16:12];
    assign shamt    = q_imem[11:7];
    assign aluop    = q_imem[6:2];
    assign imm_sext = {{15{q_imem[16]}}, q_imem[16:0]};
    assign target   = {5'd0, q_imem[26:0]};

    assign is_rtype = (opcode == OP_RTYPE);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_bex   = (opcode == OP_BEX);
    assign reads_rd = is_sw || (opcode == OP_BNE) || (opcode == OP_BLT) || (opcode == OP_JR);

    assign ctrl_readRegA = is_bex ? REG_STATUS : rs;
    assign ctrl_readRegB = is_rtype ? rt : (reads_rd ? rd : rt);

    // One adder serves add/addi and the effective address for lw/sw.
    logic [31:0] alu_a, alu_b, sum, diff;
    logic        add_ovf, sub_ovf;

    assign alu_a   = data_readRegA;
    assign alu_b   = is_rtype ? data_readRegB : imm_sext;
    assign sum     = alu_a + alu_b;
    assign diff    = alu_a - alu_b;
    assign add_ovf = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
    assign sub_ovf = (alu_a[31] != alu_b[31]) && (diff[31] != alu_a[31]);

    assign address_dmem = sum;
    assign data         = data_readRegB;
    assign address_imem = pc_q;

    // Register write selected during EXEC; overflow redirects the write to r30.
    logic        ex_we;
    logic [4:0]  ex_reg;
    logic [31:0] ex_data;

    always_comb begin
        ex_we   = 1'b0;
        ex_reg  = rd;
        ex_data = sum;
        unique case (opcode)
            OP_RTYPE: begin
                unique case (aluop)
                    ALU_ADD: begin
                        ex_we = 1'b1;
                        if (add_ovf) begin
                            ex_reg  = REG_STATUS;
                            ex_data = 32'd1;
                        end
                    end
                    ALU_SUB: begin
                        ex_we   = 1'b1;
                        ex_data = diff;
                        if (sub_ovf) begin
                            ex_reg  = REG_STATUS;
                            ex_data = 32'd3;
                        end
                    end
                    ALU_AND: begin
                        ex_we   = 1'b1;
                        ex_data = alu_a & alu_b;
                    end
                    ALU_OR: begin
                        ex_we   = 1'b1;
                        ex_data = alu_a | alu_b;
                    end
                    ALU_SLL: begin
                        ex_we   = 1'b1;
                        ex_data = alu_a << shamt;
                    end
                    ALU_SRA: begin
                        ex_we   = 1'b1;
                        ex_data = 32'($signed(alu_a) >>> shamt);
                    end
                    default: ex_we = 1'b0;
                endcase
            end
            OP_ADDI: begin
                ex_we = 1'b1;
                if (add_ovf) begin
                    ex_reg  = REG_STATUS;
                    ex_data = 32'd2;
                end
            end
            OP_JAL: begin
                ex_we   = 1'b1;
                ex_reg  = REG_LINK;
                ex_data = pc_q + 32'd1;
            end
            OP_SETX: begin
                ex_we   = 1'b1;
                ex_reg  = REG_STATUS;
                ex_data = target;
            end
            default: ex_we = 1'b0;
        endcase
    end

    // Branch operands: B carries rd, A carries rs (or r30 for bex).
    logic        br_ne, br_lt;
    logic [31:0] pc_inc;

    assign br_ne  = (data_readRegB != data_readRegA);
    assign br_lt  = ($signed(data_readRegB) < $signed(data_readRegA));
    assign pc_inc = pc_q + 32'd1;

    always_comb begin
        pc_d = pc_q;
        if (state_q == S_EXEC && !is_lw) begin
            unique case (opcode)
                OP_J, OP_JAL: pc_d = target;
                OP_JR:        pc_d = data_readRegB;
                OP_BNE:       pc_d = br_ne ? pc_inc + imm_sext : pc_inc;
                OP_BLT:       pc_d = br_lt ? pc_inc + imm_sext : pc_inc;
                OP_BEX:       pc_d = (data_readRegA != 32'd0) ? target : pc_inc;
                default:      pc_d = pc_inc;
            endcase
        end else if (state_q == S_MEM) begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        unique case (state_q)
            S_FETCH: state_d = S_EXEC;
            S_EXEC:  state_d = is_lw ? S_MEM : S_FETCH;
            S_MEM:   state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = ex_reg;
        data_writeReg    = ex_data;
        wren             = 1'b0;
        unique case (state_q)
            S_EXEC: begin
                ctrl_writeEnable = ex_we && (ex_reg != 5'd0);
                wren             = is_sw;
            end
            S_MEM: begin
                ctrl_writeEnable = (rd != 5'd0);
                ctrl_writeReg    = rd;
                data_writeReg    = q_dmem;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_processor_core.sv
// Runs directed and random programs on processor_core against an ISA-level model;
// expected regfile/RAM writes (with cycle stamps) are checked by a scoreboard monitor.
module tb_processor_core;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address_imem, q_imem;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
    logic [31:0] data_writeReg, data_readRegA, data_readRegB;
    logic        wren;
    logic [31:0] address_dmem, data, q_dmem;

    processor_core dut (
        .clock(clock), .reset(reset),
        .address_imem(address_imem), .q_imem(q_imem),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .data_writeReg(data_writeReg), .data_readRegA(data_readRegA),
        .data_readRegB(data_readRegB), .wren(wren), .address_dmem(address_dmem),
        .data(data), .q_dmem(q_dmem)
    );

    always #5 clock = ~clock;

    logic [31:0] rom [4096];
    logic [31:0] ram [4096];
    logic [31:0] rf  [32];
    logic        rf_rst = 1'b0, ram_clr = 1'b0, pre_en = 1'b0, run = 1'b0;
    logic [4:0]  pre_idx = 5'd0;
    logic [31:0] pre_val = 32'd0;
    int          cyc = 0;
    int          n_checks = 0, n_fail = 0;

    always @(posedge clock) q_imem <= rom[address_imem[11:0]];

    always @(posedge clock) begin
        if (ram_clr) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 32'd0;
        end else begin
            if (wren) ram[address_dmem[11:0]] <= data;
            q_dmem <= ram[address_dmem[11:0]];
        end
    end

    always @(posedge clock or posedge rf_rst) begin
        if (rf_rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else if (pre_en) begin
            rf[pre_idx] <= pre_val;
        end else if (ctrl_writeEnable && ctrl_writeReg != 5'd0) begin
            rf[ctrl_writeReg] <= data_writeReg;
        end
    end

    assign data_readRegA = rf[ctrl_readRegA];
    assign data_readRegB = rf[ctrl_readRegB];

    always @(posedge clock) begin
        if (!run) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          cyc;
        bit          mem;
        logic [31:0] idx;
        logic [31:0] val;
    } ev_t;

    ev_t         exp_q[$];
    logic [31:0] mregs [32];
    logic [31:0] mmem  [4096];

    localparam longint MAXI = 64'sd2147483647;
    localparam longint MINI = -64'sd2147483648;

    function automatic void push_wr(int c, int r, logic [31:0] v);
        if (r != 0) begin
            exp_q.push_back(ev_t'{cyc: c, mem: 1'b0, idx: 32'(r), val: v});
            mregs[r] = v;
        end
    endfunction

    function automatic bit ovf(longint s);
        return (s > MAXI) || (s < MINI);
    endfunction

    task automatic model_run(input int n, output int total);
        logic [31:0] pc, ins, imm, t, npc, ea, a, b;
        int op, rd, rs, rt, sh, alu, c;
        longint s;
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        for (int i = 0; i < 4096; i++) mmem[i] = 32'd0;
        exp_q.delete();
        pc = 32'd0;
        c  = 0;
        repeat (n) begin
            ins = rom[pc[11:0]];
            op = int'(ins[31:27]); rd = int'(ins[26:22]); rs = int'(ins[21:17]);
            rt = int'(ins[16:12]); sh = int'(ins[11:7]);  alu = int'(ins[6:2]);
            imm = {{15{ins[16]}}, ins[16:0]};
            t   = {5'd0, ins[26:0]};
            a   = mregs[rs];
            b   = mregs[rt];
            npc = pc + 32'd1;
            if (op == 8) begin
                ea = a + imm;
                push_wr(c + 2, rd, mmem[ea[11:0]]);
                c += 3;
            end else begin
                case (op)
                    0: case (alu)
                        0: begin
                            s = longint'($signed(a)) + longint'($signed(b));
                            if (ovf(s)) push_wr(c + 1, 30, 32'd1); else push_wr(c + 1, rd, s[31:0]);
                        end
                        1: begin
                            s = longint'($signed(a)) - longint'($signed(b));
                            if (ovf(s)) push_wr(c + 1, 30, 32'd3); else push_wr(c + 1, rd, s[31:0]);
                        end
                        2: push_wr(c + 1, rd, a & b);
                        3: push_wr(c + 1, rd, a | b);
                        4: push_wr(c + 1, rd, a << sh);
                        5: push_wr(c + 1, rd, 32'($signed(a) >>> sh));
                        default: ;
                    endcase
                    5: begin
                        s = longint'($signed(a)) + longint'($signed(imm));
                        if (ovf(s)) push_wr(c + 1, 30, 32'd2); else push_wr(c + 1, rd, s[31:0]);
                    end
                    7: begin
                        ea = a + imm;
                        exp_q.push_back(ev_t'{cyc: c + 1, mem: 1'b1, idx: ea, val: mregs[rd]});
                        mmem[ea[11:0]] = mregs[rd];
                    end
                    1: npc = t;
                    3: begin
                        push_wr(c + 1, 31, pc + 32'd1);
                        npc = t;
                    end
                    4: npc = mregs[rd];
                    2: if (mregs[rd] != mregs[rs]) npc = pc + 32'd1 + imm;
                    6: if ($signed(mregs[rd]) < $signed(mregs[rs])) npc = pc + 32'd1 + imm;
                    21: push_wr(c + 1, 30, t);
                    22: if (mregs[30] != 32'd0) npc = t;
                    default: ;
                endcase
                c += 2;
            end
            pc = npc;
        end
        total = c;
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        ev_t e;
        forever begin
            @(negedge clock);
            if (run && (ctrl_writeEnable || wren)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: cyc=%0d we=%b wren=%b reg=%0d wdata=%h addr=%h, required no write",
                             cyc, ctrl_writeEnable, wren, ctrl_writeReg, data_writeReg, address_dmem);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_kind", {30'd0, ctrl_writeEnable, wren}, {30'd0, !e.mem, e.mem});
                    chk("write_cycle", 32'(cyc), 32'(e.cyc));
                    if (e.mem) begin
                        chk("mem_addr", address_dmem, e.idx);
                        chk("mem_data", data, e.val);
                    end else begin
                        chk("reg_idx", {27'd0, ctrl_writeReg}, e.idx);
                        chk("reg_data", data_writeReg, e.val);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] enc_r(int alu, int rd, int rs, int rt, int sh);
        return {5'd0, rd[4:0], rs[4:0], rt[4:0], sh[4:0], alu[4:0], 2'b00};
    endfunction

    function automatic logic [31:0] enc_i(int op, int rd, int rs, int imm);
        return {op[4:0], rd[4:0], rs[4:0], imm[16:0]};
    endfunction

    function automatic logic [31:0] enc_j(int op, int t);
        return {op[4:0], t[26:0]};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom[i] = 32'd0;
    endtask

    task automatic run_prog(input int ninstr);
        int total;
        model_run(ninstr, total);
        reset   = 1'b1;
        run     = 1'b0;
        rf_rst  = 1'b1;
        ram_clr = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("rst_pc", address_imem, 32'd0);
        chk("rst_we", {31'd0, ctrl_writeEnable}, 32'd0);
        chk("rst_wren", {31'd0, wren}, 32'd0);
        rf_rst  = 1'b0;
        ram_clr = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b0;
        run   = 1'b1;
        repeat (total) @(negedge clock);
        #1;
        @(posedge clock);
        #1;
        run   = 1'b0;
        reset = 1'b1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        for (int r = 1; r < 32; r++) chk($sformatf("final_r%0d", r), rf[r], mregs[r]);
    endtask

    task automatic gen_random();
        logic [31:0] w;
        int k, off;
        clear_rom();
        for (int i = 0; i < 64; i++) begin
            w   = $urandom();
            k   = $urandom_range(0, 15);
            off = $urandom_range(0, 12) - 4;
            case (k)
                0, 1, 2, 3: begin w[31:27] = 5'd0; w[6:2] = 5'($urandom_range(0, 7)); end
                4, 5: w[31:27] = 5'd5;
                6:    w[31:27] = 5'd8;
                7:    w[31:27] = 5'd7;
                8:    begin w[31:27] = 5'd2; w[16:0] = off[16:0]; end
                9:    begin w[31:27] = 5'd6; w[16:0] = off[16:0]; end
                10:   w[31:27] = 5'd21;
                11:   begin w[31:27] = 5'd22; w[26:0] = 27'($urandom_range(0, 63)); end
                12:   begin w[31:27] = ($urandom_range(0, 1) != 0) ? 5'd3 : 5'd1;
                            w[26:0] = 27'($urandom_range(0, 63)); end
                13:   w[31:27] = 5'd4;
                14:   w[31:27] = 5'd9;
                default: ;
            endcase
            rom[i] = w;
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_rom();
        rom[0]  = enc_i(5, 1, 0, 5);
        rom[1]  = enc_i(5, 2, 1, -7);
        rom[2]  = enc_i(5, 3, 0, 42);
        rom[3]  = enc_i(7, 3, 0, 3);
        rom[4]  = enc_i(8, 4, 0, 3);
        rom[5]  = enc_i(2, 1, 0, 2);
        rom[6]  = enc_i(5, 5, 0, 1);
        rom[7]  = enc_i(5, 5, 0, 2);
        rom[8]  = enc_i(6, 1, 2, 5);
        rom[9]  = enc_i(6, 2, 1, 1);
        rom[10] = enc_i(5, 5, 0, 3);
        rom[11] = enc_i(5, 6, 0, 1);
        rom[12] = enc_r(4, 7, 6, 0, 30);
        rom[13] = enc_i(5, 8, 7, -1);
        rom[14] = enc_r(0, 9, 7, 8, 0);
        rom[15] = enc_r(0, 10, 9, 6, 0);
        rom[16] = enc_r(4, 11, 6, 0, 31);
        rom[17] = enc_r(1, 12, 11, 6, 0);
        rom[18] = enc_i(5, 13, 11, -1);
        rom[19] = enc_j(3, 40);
        rom[20] = enc_j(21, 7);
        rom[21] = enc_j(22, 30);
        rom[22] = enc_i(5, 5, 0, 4);
        rom[30] = enc_j(21, 0);
        rom[31] = enc_j(22, 50);
        rom[32] = enc_i(2, 1, 1, 5);
        rom[33] = enc_r(2, 15, 9, 2, 0);
        rom[34] = enc_r(3, 16, 1, 3, 0);
        rom[35] = enc_r(5, 17, 11, 0, 4);
        rom[36] = enc_j(31, 'h12345);
        rom[37] = enc_r(15, 18, 1, 1, 0);
        rom[38] = enc_j(1, 45);
        rom[40] = enc_i(5, 14, 0, 77);
        rom[41] = enc_i(4, 31, 0, 0);
        rom[45] = enc_j(1, 45);
        run_prog(36);
        chk("dir_r1", rf[1], 32'd5);
        chk("dir_r2", rf[2], 32'hFFFF_FFFE);
        chk("dir_r4_lw", rf[4], 32'd42);
        chk("dir_r5_skipped", rf[5], 32'd0);
        chk("dir_r9", rf[9], 32'h7FFF_FFFF);
        chk("dir_r10_ovf", rf[10], 32'd0);
        chk("dir_r12_ovf", rf[12], 32'd0);
        chk("dir_r13_ovf", rf[13], 32'd0);
        chk("dir_r14_jal", rf[14], 32'd77);
        chk("dir_r31_link", rf[31], 32'd20);
        chk("dir_r17_sra", rf[17], 32'hF800_0000);
        chk("dir_r30", rf[30], 32'd0);

        // Reset arriving in the MEM cycle of a lw must abort its register write.
        clear_rom();
        rom[0]  = enc_i(8, 4, 0, 3);
        rf_rst  = 1'b1;
        ram_clr = 1'b1;
        @(posedge clock);
        #1;
        rf_rst  = 1'b0;
        ram_clr = 1'b0;
        pre_en  = 1'b1;
        pre_idx = 5'd4;
        pre_val = 32'h0000_1234;
        @(posedge clock);
        #1;
        pre_en = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("lw_mem_we", {31'd0, ctrl_writeEnable}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("midlw_we", {31'd0, ctrl_writeEnable}, 32'd0);
        chk("midlw_wren", {31'd0, wren}, 32'd0);
        chk("midlw_pc", address_imem, 32'd0);
        @(posedge clock);
        #1;
        chk("midlw_r4_kept", rf[4], 32'h0000_1234);

        repeat (8) begin
            gen_random();
            run_prog(120);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
